pipe_perf_monitor: RTL and testbench

Cycle-accurate performance monitor that sits beside the five-stage pipeline in `CPU`. It consumes the hazard-detection, control, flush and write-back signals and counts run cycles, load-use stalls, flushes and retired instructions. It enforces a cycle run-limit by raising `halt_o`. A snapshot handshake freezes a coherent copy of all counters for readout without stopping them.

---
 rtl/cpu_perf_pkg.sv | 20 ++
 rtl/perf_sat_counter.sv | 36 +++
 rtl/pipe_perf_monitor.sv | 171 +++++++++++++++++
 tb/tb_pipe_perf_monitor.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
// State encoding and readout word selects are common to RTL and bench.
package cpu_perf_pkg;

    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } perf_state_t;

    localparam logic [2:0] SEL_CYCLE   = 3'd0;
    localparam logic [2:0] SEL_STALL   = 3'd1;
    localparam logic [2:0] SEL_FLUSH   = 3'd2;
    localparam logic [2:0] SEL_RETIRE  = 3'd3;
    localparam logic [2:0] SEL_LAST_PC = 3'd4;
    localparam logic [2:0] SEL_STATUS  = 3'd5;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module perf_sat_counter
    import cpu_perf_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Performance monitor beside the five-stage CPU pipeline: run FSM with cycle
// limit, four saturating event counters, last PC and a frozen snapshot bank.
module pipe_perf_monitor
    import cpu_perf_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int PC_W       = 32,
    parameter int MAX_CYCLES = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             hazard_stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             snap_req_i,
    input  logic             snap_ack_i,
    input  logic [2:0]       rd_sel_i,
    output logic             snap_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             halt_o,
    output logic             running_o
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);

    perf_state_t      state_q, state_d;
    logic             halt_q, halt_d;
    logic             running_q, running_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;
    logic [CNT_W-1:0] pc_ext;
    logic             in_run;
    logic             limit_hit;

    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] snap_cycle_q, snap_cycle_d;
    logic [CNT_W-1:0] snap_stall_q, snap_stall_d;
    logic [CNT_W-1:0] snap_flush_q, snap_flush_d;
    logic [CNT_W-1:0] snap_retire_q, snap_retire_d;
    logic [CNT_W-1:0] snap_pc_q, snap_pc_d;
    perf_state_t      snap_state_q, snap_state_d;
    logic             snap_halt_q, snap_halt_d;

    assign in_run    = (state_q == RUN);
    // The cycle that bumps the counter to the limit is the one that halts.
    assign limit_hit = (MAX_CYCLES != 0) && in_run && (cycle_cnt == LIMIT_M1);

    perf_sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i),
        .inc_i(in_run), .cnt_o(cycle_cnt)
    );
    perf_sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i),
        .inc_i(in_run && hazard_stall_i && !jump_i && !branch_i), .cnt_o(stall_cnt)
    );
    perf_sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i),
        .inc_i(in_run && flush_i), .cnt_o(flush_cnt)
    );
    perf_sat_counter #(.CNT_W(CNT_W)) u_retire (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i),
        .inc_i(in_run && retire_i), .cnt_o(retire_cnt)
    );

    generate
        if (PC_W >= CNT_W) begin : g_pc_trunc
            assign pc_ext = last_pc_q[CNT_W-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(CNT_W-PC_W){1'b0}}, last_pc_q};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        last_pc_d = last_pc_q;
        case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN: begin
                if (limit_hit && !clear_i) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                end else if (!start_i) begin
                    state_d = IDLE;
                end
            end
            HALT: if (clear_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (in_run) last_pc_d = pc_i;
        if (clear_i) begin
            halt_d    = 1'b0;
            last_pc_d = '0;
        end
        running_d = (state_d == RUN);
    end

    // Ack has priority: a request arriving while valid is always dropped.
    always_comb begin
        snap_valid_d  = snap_valid_q ? !snap_ack_i : snap_req_i;
        snap_cycle_d  = snap_cycle_q;
        snap_stall_d  = snap_stall_q;
        snap_flush_d  = snap_flush_q;
        snap_retire_d = snap_retire_q;
        snap_pc_d     = snap_pc_q;
        snap_state_d  = snap_state_q;
        snap_halt_d   = snap_halt_q;
        if (snap_req_i && !snap_valid_q) begin
            snap_cycle_d  = cycle_cnt;
            snap_stall_d  = stall_cnt;
            snap_flush_d  = flush_cnt;
            snap_retire_d = retire_cnt;
            snap_pc_d     = pc_ext;
            snap_state_d  = state_q;
            snap_halt_d   = halt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            halt_q        <= 1'b0;
            running_q     <= 1'b0;
            last_pc_q     <= '0;
            snap_valid_q  <= 1'b0;
            snap_cycle_q  <= '0;
            snap_stall_q  <= '0;
            snap_flush_q  <= '0;
            snap_retire_q <= '0;
            snap_pc_q     <= '0;
            snap_state_q  <= IDLE;
            snap_halt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            halt_q        <= halt_d;
            running_q     <= running_d;
            last_pc_q     <= last_pc_d;
            snap_valid_q  <= snap_valid_d;
            snap_cycle_q  <= snap_cycle_d;
            snap_stall_q  <= snap_stall_d;
            snap_flush_q  <= snap_flush_d;
            snap_retire_q <= snap_retire_d;
            snap_pc_q     <= snap_pc_d;
            snap_state_q  <= snap_state_d;
            snap_halt_q   <= snap_halt_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (rd_sel_i)
            SEL_CYCLE:   rd_data_o = snap_cycle_q;
            SEL_STALL:   rd_data_o = snap_stall_q;
            SEL_FLUSH:   rd_data_o = snap_flush_q;
            SEL_RETIRE:  rd_data_o = snap_retire_q;
            SEL_LAST_PC: rd_data_o = snap_pc_q;
            SEL_STATUS:  rd_data_o = CNT_W'({snap_state_q, snap_halt_q});
            default:     rd_data_o = '0;
        endcase
    end

    assign snap_valid_o = snap_valid_q;
    assign halt_o       = halt_q;
    assign running_o    = running_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor: a default instance plus a narrow
// 4-bit, unlimited instance sharing the same stimulus.
module tb_pipe_perf_monitor;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0, clear_i = 1'b0;
    logic          hazard_stall_i = 1'b0, jump_i = 1'b0, branch_i = 1'b0;
    logic          flush_i = 1'b0, retire_i = 1'b0;
    logic [31:0]   pc_i = '0;
    logic          snap_req_i = 1'b0, snap_ack_i = 1'b0;
    logic [2:0]    rd_sel_i = '0;

    logic          snap_valid_o, halt_o, running_o;
    logic [W-1:0]  rd_data_o;
    logic          s_snap_valid, s_halt, s_running;
    logic [3:0]    s_rd_data;

    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  exp_q[$];

    pipe_perf_monitor #(.CNT_W(32), .PC_W(32), .MAX_CYCLES(20)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .hazard_stall_i(hazard_stall_i), .jump_i(jump_i), .branch_i(branch_i),
        .flush_i(flush_i), .retire_i(retire_i), .pc_i(pc_i),
        .snap_req_i(snap_req_i), .snap_ack_i(snap_ack_i), .rd_sel_i(rd_sel_i),
        .snap_valid_o(snap_valid_o), .rd_data_o(rd_data_o),
        .halt_o(halt_o), .running_o(running_o)
    );

    pipe_perf_monitor #(.CNT_W(4), .PC_W(32), .MAX_CYCLES(0)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .hazard_stall_i(hazard_stall_i), .jump_i(jump_i), .branch_i(branch_i),
        .flush_i(flush_i), .retire_i(retire_i), .pc_i(pc_i),
        .snap_req_i(snap_req_i), .snap_ack_i(snap_ack_i), .rd_sel_i(rd_sel_i),
        .snap_valid_o(s_snap_valid), .rd_data_o(s_rd_data),
        .halt_o(s_halt), .running_o(s_running)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    // Driver tasks: advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic snap_take();
        snap_req_i = 1'b1;
        cyc();
        snap_req_i = 1'b0;
    endtask

    task automatic snap_release();
        snap_ack_i = 1'b1;
        cyc();
        snap_ack_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        rst_i = 1'b0;
        cyc();
        cyc();
        total++;
        if ({snap_valid_o, halt_o, running_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000", {snap_valid_o, halt_o, running_o});
        end
        for (int s = 0; s < 8; s++) exp_q.push_back('0);
        for (int s = 0; s < 8; s++) begin
            rd_sel_i = 3'(s);
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL reset_rd sel=%0d got=%0h exp=%0h", s, rd_data_o, e);
            end
        end
        rst_i = 1'b1;
        cyc();
    endtask

    task automatic test_run_limit();
        logic [W-1:0] e;
        pc_i = 32'h0000_1000;
        start_i = 1'b1;
        cyc();
        total++;
        if ({running_o, halt_o} !== 2'b10) begin
            bad++;
            $display("FAIL limit_start run/halt got=%b exp=10", {running_o, halt_o});
        end
        repeat (19) cyc();
        total++;
        if ({running_o, halt_o} !== 2'b10) begin
            bad++;
            $display("FAIL limit_edge19 run/halt got=%b exp=10", {running_o, halt_o});
        end
        cyc();
        total++;
        if ({running_o, halt_o} !== 2'b01) begin
            bad++;
            $display("FAIL limit_edge20 run/halt got=%b exp=01", {running_o, halt_o});
        end
        repeat (5) cyc();
        snap_take();
        total++;
        if (snap_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL limit_snap_valid got=%b exp=1", snap_valid_o);
        end
        exp_q.push_back(32'd20);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h0000_1000);
        exp_q.push_back(32'd5);
        for (int s = 0; s < 6; s++) begin
            rd_sel_i = 3'(s);
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL limit_rd sel=%0d got=%0h exp=%0h", s, rd_data_o, e);
            end
        end
        snap_release();
        total++;
        if (snap_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL limit_ack got=%b exp=0", snap_valid_o);
        end
        start_i = 1'b0;
        do_clear();
        total++;
        if ({running_o, halt_o} !== 2'b00) begin
            bad++;
            $display("FAIL limit_clear run/halt got=%b exp=00", {running_o, halt_o});
        end
        exp_q.push_back(32'd20);
        rd_sel_i = 3'd0;
        #1;
        e = exp_q.pop_front();
        total++;
        if (rd_data_o !== e) begin
            bad++;
            $display("FAIL limit_snap_kept got=%0h exp=%0h", rd_data_o, e);
        end
    endtask

    task automatic test_events();
        logic [W-1:0] e;
        logic [3:0] pat [8];
        pat = '{4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1010, 4'b0001, 4'b1101, 4'b0000};
        pc_i = 32'h0000_2000;
        start_i = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            {hazard_stall_i, jump_i, branch_i, flush_i} = pat[i];
            cyc();
        end
        {hazard_stall_i, jump_i, branch_i, flush_i} = 4'b0000;
        start_i = 1'b0;
        cyc();
        total++;
        if (running_o !== 1'b0) begin
            bad++;
            $display("FAIL events_stop running got=%b exp=0", running_o);
        end
        snap_take();
        exp_q.push_back(32'd9);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h0000_2000);
        exp_q.push_back(32'd0);
        for (int s = 0; s < 6; s++) begin
            rd_sel_i = 3'(s);
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL events_rd sel=%0d got=%0h exp=%0h", s, rd_data_o, e);
            end
        end
        snap_release();
    endtask

    task automatic test_snapshot_race();
        logic [W-1:0] e;
        logic [31:0] lp;
        do_clear();
        start_i = 1'b1;
        cyc();
        hazard_stall_i = 1'b1;
        lp = '0;
        for (int k = 0; k < 6; k++) begin
            pc_i = $urandom;
            lp = pc_i;
            cyc();
        end
        pc_i = $urandom_range(32'hFFFF, 1);
        snap_take();
        hazard_stall_i = 1'b0;
        total++;
        if (snap_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL race_valid got=%b exp=1", snap_valid_o);
        end
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(lp);
        exp_q.push_back(32'd2);
        for (int s = 0; s < 6; s++) begin
            rd_sel_i = 3'(s);
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL race_rd sel=%0d got=%0h exp=%0h", s, rd_data_o, e);
            end
        end
        snap_take();
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd6);
        for (int s = 0; s < 2; s++) begin
            rd_sel_i = 3'(s);
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL race_drop sel=%0d got=%0h exp=%0h", s, rd_data_o, e);
            end
        end
        snap_ack_i = 1'b1;
        snap_req_i = 1'b1;
        cyc();
        snap_ack_i = 1'b0;
        snap_req_i = 1'b0;
        total++;
        if (snap_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL race_ack_wins got=%b exp=0", snap_valid_o);
        end
        cyc();
        total++;
        if (snap_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL race_req_dropped got=%b exp=0", snap_valid_o);
        end
        lp = pc_i;
        snap_take();
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(lp);
        exp_q.push_back(32'd2);
        for (int s = 0; s < 6; s++) begin
            rd_sel_i = 3'(s);
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL race_resnap sel=%0d got=%0h exp=%0h", s, rd_data_o, e);
            end
        end
        snap_release();
        start_i = 1'b0;
        cyc();
    endtask

    task automatic test_saturation();
        logic [W-1:0] e;
        do_clear();
        start_i = 1'b1;
        cyc();
        retire_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if ({s_running, s_halt} !== 2'b10) begin
                bad++;
                $display("FAIL sat_nohalt i=%0d run/halt got=%b exp=10", i, {s_running, s_halt});
            end
        end
        retire_i = 1'b0;
        start_i = 1'b0;
        cyc();
        snap_take();
        total++;
        if (s_snap_valid !== 1'b1) begin
            bad++;
            $display("FAIL sat_valid got=%b exp=1", s_snap_valid);
        end
        exp_q.push_back(32'd15);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd15);
        for (int s = 0; s < 4; s++) begin
            rd_sel_i = 3'(s);
            #1;
            e = exp_q.pop_front();
            total++;
            if ({28'd0, s_rd_data} !== e) begin
                bad++;
                $display("FAIL sat_rd sel=%0d got=%0h exp=%0h", s, s_rd_data, e);
            end
        end
        snap_release();
        do_clear();
    endtask

    task automatic test_start_pause();
        logic [W-1:0] e;
        start_i = 1'b1;
        cyc();
        repeat (4) cyc();
        start_i = 1'b0;
        cyc();
        cyc();
        cyc();
        snap_take();
        exp_q.push_back(32'd5);
        rd_sel_i = 3'd0;
        #1;
        e = exp_q.pop_front();
        total++;
        if (rd_data_o !== e) begin
            bad++;
            $display("FAIL pause_freeze got=%0d exp=%0d", rd_data_o, e);
        end
        snap_release();
        start_i = 1'b1;
        cyc();
        flush_i = 1'b1;
        repeat (3) cyc();
        flush_i = 1'b0;
        snap_take();
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd3);
        for (int s = 0; s < 2; s++) begin
            rd_sel_i = (s == 0) ? 3'd0 : 3'd2;
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL pause_resume idx=%0d got=%0d exp=%0d", s, rd_data_o, e);
            end
        end
        snap_release();
        clear_i = 1'b1;
        flush_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        flush_i = 1'b0;
        snap_take();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        for (int s = 0; s < 2; s++) begin
            rd_sel_i = (s == 0) ? 3'd0 : 3'd2;
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL pause_clear idx=%0d got=%0d exp=%0d", s, rd_data_o, e);
            end
        end
        snap_release();
    endtask

    task automatic test_reset_mid_snapshot();
        logic [W-1:0] e;
        retire_i = 1'b1;
        repeat (3) cyc();
        snap_take();
        retire_i = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        total++;
        if ({snap_valid_o, halt_o, running_o} !== 3'b000) begin
            bad++;
            $display("FAIL midrst_flags got=%b exp=000", {snap_valid_o, halt_o, running_o});
        end
        for (int s = 0; s < 6; s++) exp_q.push_back('0);
        for (int s = 0; s < 6; s++) begin
            rd_sel_i = 3'(s);
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL midrst_rd sel=%0d got=%0h exp=%0h", s, rd_data_o, e);
            end
        end
        start_i = 1'b0;
        cyc();
        rst_i = 1'b1;
        cyc();
        snap_take();
        exp_q.push_back(32'd0);
        rd_sel_i = 3'd5;
        #1;
        e = exp_q.pop_front();
        total++;
        if (rd_data_o !== e || running_o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle status=%0h running=%b exp=0/0", rd_data_o, running_o);
        end
        snap_release();
    endtask

    initial begin
        test_reset();
        test_run_limit();
        test_events();
        test_snapshot_race();
        test_saturation();
        test_start_pause();
        test_reset_mid_snapshot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
